attribute_text_renderer: RTL and testbench

ATTRIBUTE_TEXT_RENDERER -- requirements
Module: attribute_text_renderer

---
 rtl/attribute_text_renderer.sv | 218 +++++++++++++++++++++
 tb/tb_attribute_text_renderer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/attribute_text_renderer.sv
// Attribute text-mode pixel renderer: cell addressing, font fetch, blink/cursor
// handling and 16-colour palette mapping in a fixed-latency, stall-free pipeline.
module attribute_text_renderer #(
    parameter int unsigned CELL_WIDTH   = 8,
    parameter int unsigned CELL_HEIGHT  = 16,
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 30,
    parameter int unsigned MEM_LATENCY  = 1,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [9:0]            VGA_X,
    input  logic [9:0]            VGA_Y,
    input  logic                  DisplayEnable,
    input  logic                  FrameStart,
    input  logic [7:0]            CursorX,
    input  logic [7:0]            CursorY,
    input  logic                  CursorEnable,
    output logic [7:0]            CellX,
    output logic [7:0]            CellY,
    input  logic [15:0]           CellData,
    output logic [11:0]           FontAddr,
    input  logic [CELL_WIDTH-1:0] FontData,
    output logic [7:0]            VGA_R,
    output logic [7:0]            VGA_G,
    output logic [7:0]            VGA_B,
    output logic                  PixelValid
);

    localparam int unsigned     DL      = MEM_LATENCY;
    localparam logic [9:0]      CW      = 10'(CELL_WIDTH);
    localparam logic [9:0]      CH      = 10'(CELL_HEIGHT);
    localparam logic [9:0]      COLS_L  = 10'(COLS);
    localparam logic [9:0]      ROWS_L  = 10'(ROWS);
    localparam logic [4:0]      CH_5    = 5'(CELL_HEIGHT);
    localparam logic [11:0]     CH_12   = 12'(CELL_HEIGHT);
    localparam logic [3:0]      XO_LAST = 4'(CELL_WIDTH - 1);
    localparam int unsigned     FCW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FCW-1:0]  FC_LAST = FCW'(BLINK_FRAMES - 1);

    function automatic logic [23:0] palette(input logic [3:0] idx);
        logic [23:0] rgb;
        case (idx[2:0])
            3'd0:    rgb = 24'h000000;
            3'd1:    rgb = 24'h0000AA;
            3'd2:    rgb = 24'h00AA00;
            3'd3:    rgb = 24'h00AAAA;
            3'd4:    rgb = 24'hAA0000;
            3'd5:    rgb = 24'hAA00AA;
            3'd6:    rgb = 24'hAA5500;
            default: rgb = 24'hAAAAAA;
        endcase
        if (idx[3]) rgb = rgb + 24'h555555;
        if (idx == 4'd14) rgb = 24'hFFFF55;
        return rgb;
    endfunction

    logic [9:0] cx_c, cy_c;
    logic [3:0] xo_c, yo_c;

    always_comb begin
        cx_c = VGA_X / CW;
        cy_c = VGA_Y / CH;
        xo_c = 4'(VGA_X % CW);
        yo_c = 4'(VGA_Y % CH);
    end

    // Delay line that keeps coordinates aligned with the character-buffer read
    logic [9:0] d_cx  [0:DL];
    logic [9:0] d_cy  [0:DL];
    logic [3:0] d_xo  [0:DL];
    logic [3:0] d_yo  [0:DL];
    logic       d_de  [0:DL];
    logic       d_vis [0:DL];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            CellX <= '0;
            CellY <= '0;
            for (int i = 0; i <= int'(DL); i++) begin
                d_de[i]  <= 1'b0;
                d_vis[i] <= 1'b0;
            end
        end else begin
            CellX    <= cx_c[7:0];
            CellY    <= cy_c[7:0];
            d_de[0]  <= DisplayEnable;
            d_vis[0] <= DisplayEnable && (cx_c < COLS_L) && (cy_c < ROWS_L);
            for (int i = 1; i <= int'(DL); i++) begin
                d_de[i]  <= d_de[i-1];
                d_vis[i] <= d_vis[i-1];
            end
        end
    end

    always_ff @(posedge Clk) begin
        d_cx[0] <= cx_c;
        d_cy[0] <= cy_c;
        d_xo[0] <= xo_c;
        d_yo[0] <= yo_c;
        for (int i = 1; i <= int'(DL); i++) begin
            d_cx[i] <= d_cx[i-1];
            d_cy[i] <= d_cy[i-1];
            d_xo[i] <= d_xo[i-1];
            d_yo[i] <= d_yo[i-1];
        end
    end

    // Frame counter and blink phase
    logic [FCW-1:0] frame_cnt;
    logic           blink_phase;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (FrameStart) begin
            if (frame_cnt == FC_LAST) begin
                frame_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                frame_cnt <= frame_cnt + FCW'(1);
            end
        end
    end

    // Font-address stage: attributes, blink and cursor are frozen here
    logic       cur_hit_c;
    logic [3:0] f_xo, f_fg;
    logic [2:0] f_bg;
    logic       f_sup, f_cur, f_de, f_vis;

    always_comb begin
        cur_hit_c = CursorEnable && !blink_phase
                    && (d_cx[DL] == {2'b00, CursorX})
                    && (d_cy[DL] == {2'b00, CursorY})
                    && (({1'b0, d_yo[DL]} + 5'd2) >= CH_5);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            FontAddr <= '0;
            f_de     <= 1'b0;
            f_vis    <= 1'b0;
        end else begin
            FontAddr <= 12'(CellData[7:0]) * CH_12 + 12'(d_yo[DL]);
            f_de     <= d_de[DL];
            f_vis    <= d_vis[DL];
        end
    end

    always_ff @(posedge Clk) begin
        f_xo  <= d_xo[DL];
        f_fg  <= CellData[11:8];
        f_bg  <= CellData[14:12];
        f_sup <= CellData[15] && blink_phase;
        f_cur <= cur_hit_c;
    end

    // Hold attributes while the font ROM is read
    logic [3:0] b_xo, b_fg;
    logic [2:0] b_bg;
    logic       b_sup, b_cur, b_de, b_vis;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            b_de  <= 1'b0;
            b_vis <= 1'b0;
        end else begin
            b_de  <= f_de;
            b_vis <= f_vis;
        end
    end

    always_ff @(posedge Clk) begin
        b_xo  <= f_xo;
        b_fg  <= f_fg;
        b_bg  <= f_bg;
        b_sup <= f_sup;
        b_cur <= f_cur;
    end

    // Pixel select: MSB of the font row is the leftmost pixel
    logic       font_bit_c, fg_on_c;
    logic [3:0] p_idx;
    logic       p_de, p_vis;

    always_comb begin
        font_bit_c = |(FontData & (CELL_WIDTH'(1) << (XO_LAST - b_xo)));
        fg_on_c    = b_cur || (font_bit_c && !b_sup);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            p_de  <= 1'b0;
            p_vis <= 1'b0;
        end else begin
            p_de  <= b_de;
            p_vis <= b_vis;
        end
    end

    always_ff @(posedge Clk) begin
        p_idx <= fg_on_c ? b_fg : {1'b0, b_bg};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            {VGA_R, VGA_G, VGA_B} <= 24'h000000;
            PixelValid            <= 1'b0;
        end else begin
            {VGA_R, VGA_G, VGA_B} <= p_vis ? palette(p_idx) : 24'h000000;
            PixelValid            <= p_de;
        end
    end

endmodule

// File: tb/tb_attribute_text_renderer.sv
// Scoreboard bench for attribute_text_renderer: two instances (default and
// CELL_WIDTH=9 / MEM_LATENCY=3) fed the same pixel stream.
module tb_attribute_text_renderer;

    localparam int unsigned L1 = 1;
    localparam int unsigned L2 = 3;

    typedef struct packed {
        logic        chk;
        logic        v;
        logic [23:0] rgb;
        logic [15:0] id;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] vga_x, vga_y;
    logic       de, fs;
    logic [7:0] cur_x, cur_y;
    logic       cur_en;

    logic [7:0]  cell_x1, cell_y1, cell_x2, cell_y2;
    logic [15:0] cell_data1, cell_data2, cd2_a, cd2_b;
    logic [11:0] font_addr1, font_addr2;
    logic [7:0]  font_data1;
    logic [8:0]  font_data2;
    logic [7:0]  r1, g1, b1, r2, g2, b2;
    logic        pv1, pv2;

    logic [15:0] cell_mem [0:255][0:255];
    logic [7:0]  font1 [0:4095];
    logic [8:0]  font2 [0:4095];

    exp_t q1[$];
    exp_t q2[$];
    int   checks = 0;
    int   errors = 0;
    int   vid = 0;

    always #5 clk = ~clk;

    attribute_text_renderer #(.MEM_LATENCY(L1)) u_dut1 (
        .Clk(clk), .Reset(rst), .VGA_X(vga_x), .VGA_Y(vga_y),
        .DisplayEnable(de), .FrameStart(fs),
        .CursorX(cur_x), .CursorY(cur_y), .CursorEnable(cur_en),
        .CellX(cell_x1), .CellY(cell_y1), .CellData(cell_data1),
        .FontAddr(font_addr1), .FontData(font_data1),
        .VGA_R(r1), .VGA_G(g1), .VGA_B(b1), .PixelValid(pv1)
    );

    attribute_text_renderer #(.CELL_WIDTH(9), .MEM_LATENCY(L2)) u_dut2 (
        .Clk(clk), .Reset(rst), .VGA_X(vga_x), .VGA_Y(vga_y),
        .DisplayEnable(de), .FrameStart(fs),
        .CursorX(cur_x), .CursorY(cur_y), .CursorEnable(cur_en),
        .CellX(cell_x2), .CellY(cell_y2), .CellData(cell_data2),
        .FontAddr(font_addr2), .FontData(font_data2),
        .VGA_R(r2), .VGA_G(g2), .VGA_B(b2), .PixelValid(pv2)
    );

    // Character buffer (latency 1 and 3) and font ROM models
    always @(posedge clk) begin
        cell_data1 <= cell_mem[cell_y1][cell_x1];
        font_data1 <= font1[font_addr1];
        cd2_a      <= cell_mem[cell_y2][cell_x2];
        cd2_b      <= cd2_a;
        cell_data2 <= cd2_b;
        font_data2 <= font2[font_addr2];
    end

    // Monitor: one expected entry per cycle, due MEM_LATENCY+4 edges later
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q1.size() > int'(L1 + 4)) begin
            e = q1.pop_front();
            if (e.chk) begin
                checks++;
                if (pv1 !== e.v || {r1, g1, b1} !== e.rgb) begin
                    errors++;
                    $display("FAIL dut1 vec %0d: got valid=%b rgb=%h, expected valid=%b rgb=%h",
                             e.id, pv1, {r1, g1, b1}, e.v, e.rgb);
                end
            end
        end
        if (q2.size() > int'(L2 + 4)) begin
            e = q2.pop_front();
            if (e.chk) begin
                checks++;
                if (pv2 !== e.v || {r2, g2, b2} !== e.rgb) begin
                    errors++;
                    $display("FAIL dut2 vec %0d: got valid=%b rgb=%h, expected valid=%b rgb=%h",
                             e.id, pv2, {r2, g2, b2}, e.v, e.rgb);
                end
            end
        end
    end

    task automatic pix(input logic [9:0] x, input logic [9:0] y, input logic d,
                       input logic f, input logic [23:0] ergb, input logic [1:0] mask);
        exp_t e;
        @(negedge clk);
        rst   = 1'b0;
        vga_x = x;
        vga_y = y;
        de    = d;
        fs    = f;
        vid++;
        e = '{chk: mask[0], v: d, rgb: ergb, id: 16'(vid)};
        q1.push_back(e);
        e.chk = mask[1];
        q2.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(10'd0, 10'd0, 1'b0, 1'b0, 24'h0, 2'b11);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) pix(10'd0, 10'd0, 1'b0, 1'b1, 24'h0, 2'b11);
    endtask

    // Reset kills everything in flight, so all pending expectations become black/invalid
    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        de  = 1'b0;
        fs  = 1'b0;
        for (int i = 0; i < q1.size(); i++) begin
            e = q1[i]; e.v = 1'b0; e.rgb = 24'h0; q1[i] = e;
        end
        for (int i = 0; i < q2.size(); i++) begin
            e = q2[i]; e.v = 1'b0; e.rgb = 24'h0; q2[i] = e;
        end
        vid++;
        e = '{chk: 1'b1, v: 1'b0, rgb: 24'h0, id: 16'(vid)};
        q1.push_back(e);
        q2.push_back(e);
    endtask

    initial begin
        rst = 1'b1; vga_x = '0; vga_y = '0; de = 1'b0; fs = 1'b0;
        cur_x = 8'd3; cur_y = 8'd2; cur_en = 1'b1;
        for (int y = 0; y < 256; y++)
            for (int x = 0; x < 256; x++) cell_mem[y][x] = 16'h0000;
        for (int a = 0; a < 4096; a++) begin
            font1[a] = 8'h00;
            font2[a] = 9'h000;
        end
        cell_mem[0][0]  = 16'h0141;
        cell_mem[0][1]  = 16'h8F41;
        cell_mem[0][2]  = 16'h0E41;
        cell_mem[0][4]  = 16'h6041;
        cell_mem[0][5]  = 16'h7941;
        cell_mem[2][3]  = 16'h1C00;
        cell_mem[0][79] = 16'h1000;
        cell_mem[0][80] = 16'h1000;
        cell_mem[29][0] = 16'h1000;
        cell_mem[30][0] = 16'h1000;
        font1[12'h410]  = 8'h80;
        font2[12'h410]  = 9'h100;

        repeat (3) do_reset();

        // Basic pixel at both latencies / widths
        pix(10'd0, 10'd0, 1'b1, 1'b0, 24'h0000AA, 2'b11);
        pix(10'd1, 10'd0, 1'b1, 1'b0, 24'h000000, 2'b11);
        idle(2);

        // Palette entries
        pix(10'd16, 10'd0, 1'b1, 1'b0, 24'hFFFF55, 2'b01);
        pix(10'd32, 10'd0, 1'b1, 1'b0, 24'h000000, 2'b01);
        pix(10'd33, 10'd0, 1'b1, 1'b0, 24'hAA5500, 2'b01);
        pix(10'd40, 10'd0, 1'b1, 1'b0, 24'h5555FF, 2'b01);
        pix(10'd41, 10'd0, 1'b1, 1'b0, 24'hAAAAAA, 2'b01);
        pix(10'd8,  10'd0, 1'b1, 1'b0, 24'hFFFFFF, 2'b01);
        pix(10'd9,  10'd0, 1'b1, 1'b0, 24'h000000, 2'b01);

        // Cursor underline rows
        for (int x = 24; x < 32; x++) pix(10'(x), 10'd46, 1'b1, 1'b0, 24'hFF5555, 2'b01);
        pix(10'd24, 10'd45, 1'b1, 1'b0, 24'h0000AA, 2'b01);
        pix(10'd25, 10'd47, 1'b1, 1'b0, 24'hFF5555, 2'b01);
        idle(8);
        cur_en = 1'b0;
        pix(10'd24, 10'd46, 1'b1, 1'b0, 24'h0000AA, 2'b01);
        idle(8);
        cur_en = 1'b1;

        // Visible-area bounds
        pix(10'd639, 10'd0,   1'b1, 1'b0, 24'h0000AA, 2'b01);
        pix(10'd640, 10'd0,   1'b1, 1'b0, 24'h000000, 2'b01);
        pix(10'd0,   10'd464, 1'b1, 1'b0, 24'h0000AA, 2'b01);
        pix(10'd0,   10'd480, 1'b1, 1'b0, 24'h000000, 2'b01);
        pix(10'd0,   10'd0,   1'b0, 1'b0, 24'h000000, 2'b01);

        // Blink phase toggles every 16 frames
        idle(8);
        frames(16);
        pix(10'd8,  10'd0,  1'b1, 1'b0, 24'h000000, 2'b01);
        pix(10'd0,  10'd0,  1'b1, 1'b0, 24'h0000AA, 2'b01);
        pix(10'd24, 10'd46, 1'b1, 1'b0, 24'h0000AA, 2'b01);
        idle(8);
        frames(16);
        pix(10'd8, 10'd0, 1'b1, 1'b0, 24'hFFFFFF, 2'b01);
        idle(8);
        frames(21);
        pix(10'd8, 10'd0, 1'b1, 1'b0, 24'h000000, 2'b01);

        // Mid-line reset with phase=1 and counter=5
        for (int x = 0; x < 8; x++)
            pix(10'(x), 10'd0, 1'b1, 1'b0, (x == 0) ? 24'h0000AA : 24'h000000, 2'b01);
        do_reset();
        pix(10'd8, 10'd0, 1'b1, 1'b0, 24'hFFFFFF, 2'b01);
        idle(8);
        frames(15);
        pix(10'd8, 10'd0, 1'b1, 1'b0, 24'hFFFFFF, 2'b01);
        idle(8);
        frames(1);
        pix(10'd8, 10'd0, 1'b1, 1'b0, 24'h000000, 2'b01);

        idle(10);
        @(posedge clk);
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
